// File: rtl/fc_cnt_pkg.sv
// rtl/fc_cnt_pkg.sv - shared width, sync depth and FSM state type for the gray count receiver
`ifndef INWD
`define INWD 8
`endif

package fc_cnt_pkg;

  localparam int CNT_W      = `INWD;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

endpackage

// File: rtl/DEF.sv
// rtl/DEF.sv - project-wide width define for the count interface
`ifndef INWD
`define INWD 8
`endif

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational gray to binary decode
module gray2bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the xor of all gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_cnt_receiver.sv
// rtl/gray_cnt_receiver.sv - synchronizes a remote gray counter and turns unit steps into pending events
module gray_cnt_receiver
  import fc_cnt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic         consume,
  input  logic         clr_err,
  output logic [W-1:0] cnt_bin,
  output logic [W-1:0] pending,
  output logic         evt_valid,
  output logic         err
);

  localparam logic [1:0] FILL_DONE = 2'(SYNC_DEPTH);

  state_t       state, state_nxt;
  logic [W-1:0] sync1, sync2;
  logic [W-1:0] decoded;
  logic [W-1:0] prev, prev_nxt;
  logic [W-1:0] pend_nxt;
  logic         err_nxt;
  logic [1:0]   fill, fill_nxt;
  logic [W-1:0] delta;
  logic         step_one, jump, inc, cons_ok, ovf;

  gray2bin #(.W(W)) u_gray2bin (
    .gray (sync2),
    .bin  (decoded)
  );

  assign delta     = cnt_bin - prev;
  assign step_one  = (state == ST_TRACK) && (delta == W'(1));
  assign jump      = (state == ST_TRACK) && (delta != W'(0)) && (delta != W'(1));
  assign inc       = step_one;
  assign cons_ok   = consume && (pending != '0);
  // A simultaneous consume absorbs the increment, so only a bare increment can overflow.
  assign ovf       = inc && !cons_ok && (pending == '1);
  assign evt_valid = (pending != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bin <= '0;
      prev    <= '0;
      pending <= '0;
      err     <= 1'b0;
      fill    <= '0;
    end else begin
      cnt_bin <= decoded;
      prev    <= prev_nxt;
      pending <= pend_nxt;
      err     <= err_nxt;
      fill    <= fill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (fill == FILL_DONE) state_nxt = ST_TRACK;
      ST_TRACK: if (jump || ovf) state_nxt = ST_ERR;
      ST_ERR:   if (clr_err) state_nxt = ST_TRACK;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    prev_nxt = prev;
    pend_nxt = pending;
    err_nxt  = err;
    fill_nxt = fill;
    case (state)
      ST_INIT: begin
        // Seed from the live decode so the first TRACK cycle sees delta 0.
        if (fill == FILL_DONE) prev_nxt = decoded;
        else                   fill_nxt = fill + 2'd1;
      end
      ST_TRACK: begin
        if (step_one) prev_nxt = cnt_bin;
        if (jump) begin
          prev_nxt = cnt_bin;
          err_nxt  = 1'b1;
        end
      end
      ST_ERR: begin
        prev_nxt = cnt_bin;
        if (clr_err) err_nxt = 1'b0;
      end
      default: ;
    endcase

    if (ovf)                  err_nxt  = 1'b1;
    else if (inc && !cons_ok) pend_nxt = pending + W'(1);
    else if (!inc && cons_ok) pend_nxt = pending - W'(1);
  end

endmodule

// File: tb/tb_gray_cnt_receiver.sv
// tb/tb_gray_cnt_receiver.sv - self-checking bench for gray_cnt_receiver
module tb_gray_cnt_receiver;
  import fc_cnt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gray_in;
  logic       consume;
  logic       clr_err;
  logic [7:0] cnt_bin;
  logic [7:0] pending;
  logic       evt_valid;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;
  int remote;
  int exp_pend;

  gray_cnt_receiver #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .consume   (consume),
    .clr_err   (clr_err),
    .cnt_bin   (cnt_bin),
    .pending   (pending),
    .evt_valid (evt_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_gray(input int v);
    logic [7:0] b;
    b = v[7:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int v);
    gray_in = to_gray(v);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    remote = v;
    exp_pend = 0;
  endtask

  task automatic step_to(input int v);
    gray_in = to_gray(v);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    gray_in = to_gray(5);
    rst_n = 1'b0;
    tick();
    n_cmp++; if (pending !== 8'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
    n_cmp++; if (cnt_bin !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_bin: got %0d want 0", cnt_bin); end
    n_cmp++; if (err !== 1'b0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got err=%b evt=%b want 0 0", err, evt_valid); end
    n_cmp++; if (dut.state !== ST_INIT) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_INIT); end
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (dut.state !== ST_TRACK) begin n_fail++; $display("FAIL init_state: got %0d want %0d", dut.state, ST_TRACK); end
    n_cmp++; if (cnt_bin !== 8'd5) begin n_fail++; $display("FAIL init_cnt_bin: got %0d want 5", cnt_bin); end
    n_cmp++; if (pending !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL init_pending: got p=%0d err=%b want 0 0", pending, err); end
  endtask

  task automatic test_latency();
    gray_in = to_gray(6);
    repeat (3) tick();
    n_cmp++; if (pending !== 8'd0) begin n_fail++; $display("FAIL lat_early: got %0d want 0 after edge N+2", pending); end
    tick();
    n_cmp++; if (pending !== 8'd1 || cnt_bin !== 8'd6) begin n_fail++; $display("FAIL lat_n3: got p=%0d cnt=%0d want 1 6", pending, cnt_bin); end
    step_to(7);
    n_cmp++; if (pending !== 8'd2 || evt_valid !== 1'b1 || cnt_bin !== 8'd7) begin n_fail++; $display("FAIL two_steps: got p=%0d evt=%b cnt=%0d want 2 1 7", pending, evt_valid, cnt_bin); end
  endtask

  task automatic test_wrap();
    apply_reset(254);
    step_to(255);
    step_to(0);
    n_cmp++; if (pending !== 8'd2 || err !== 1'b0 || cnt_bin !== 8'd0) begin n_fail++; $display("FAIL wrap: got p=%0d err=%b cnt=%0d want 2 0 0", pending, err, cnt_bin); end
  endtask

  task automatic test_jump();
    apply_reset(10);
    step_to(14);
    n_cmp++; if (err !== 1'b1 || dut.state !== ST_ERR || pending !== 8'd0) begin n_fail++; $display("FAIL jump: got err=%b st=%0d p=%0d want 1 %0d 0", err, dut.state, pending, ST_ERR); end
    step_to(15);
    n_cmp++; if (pending !== 8'd0 || cnt_bin !== 8'd15) begin n_fail++; $display("FAIL err_nocount: got p=%0d cnt=%0d want 0 15", pending, cnt_bin); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    n_cmp++; if (err !== 1'b0 || dut.state !== ST_TRACK) begin n_fail++; $display("FAIL clr_err: got err=%b st=%0d want 0 %0d", err, dut.state, ST_TRACK); end
    step_to(16);
    n_cmp++; if (pending !== 8'd1) begin n_fail++; $display("FAIL resume: got %0d want 1", pending); end
  endtask

  task automatic test_back_to_back();
    apply_reset(20);
    step_to(21);
    step_to(22);
    step_to(23);
    gray_in = to_gray(24);
    repeat (3) tick();
    consume = 1'b1;
    tick();
    consume = 1'b0;
    n_cmp++; if (pending !== 8'd3 || cnt_bin !== 8'd24) begin n_fail++; $display("FAIL inc_and_consume: got p=%0d cnt=%0d want 3 24", pending, cnt_bin); end
    consume = 1'b1;
    repeat (3) tick();
    consume = 1'b0;
    n_cmp++; if (pending !== 8'd0) begin n_fail++; $display("FAIL drain: got %0d want 0", pending); end
    consume = 1'b1;
    tick();
    consume = 1'b0;
    n_cmp++; if (pending !== 8'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL consume_empty: got p=%0d evt=%b want 0 0", pending, evt_valid); end
  endtask

  task automatic test_random();
    int act;
    int k;
    apply_reset($urandom_range(0, 255));
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 2);
      if (act == 0) begin
        remote = (remote + 1) % 256;
        step_to(remote);
        exp_pend = exp_pend + 1;
      end else if (act == 1) begin
        k = $urandom_range(1, 3);
        consume = 1'b1;
        repeat (k) tick();
        consume = 1'b0;
        tick();
        exp_pend = (exp_pend > k) ? exp_pend - k : 0;
      end else begin
        repeat ($urandom_range(1, 4)) tick();
      end
      n_cmp++;
      if (pending !== 8'(exp_pend) || cnt_bin !== 8'(remote) || evt_valid !== (exp_pend != 0) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: got p=%0d cnt=%0d evt=%b err=%b want %0d %0d %b 0", it, pending, cnt_bin, evt_valid, err, exp_pend, remote, exp_pend != 0);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset(0);
    for (int v = 1; v <= 255; v++) step_to(v);
    n_cmp++; if (pending !== 8'd255 || err !== 1'b0) begin n_fail++; $display("FAIL fill_255: got p=%0d err=%b want 255 0", pending, err); end
    step_to(0);
    n_cmp++; if (pending !== 8'd255 || err !== 1'b1 || dut.state !== ST_ERR) begin n_fail++; $display("FAIL saturate: got p=%0d err=%b st=%0d want 255 1 %0d", pending, err, dut.state, ST_ERR); end
    consume = 1'b1;
    tick();
    consume = 1'b0;
    step_to(1);
    n_cmp++; if (pending !== 8'd254 || cnt_bin !== 8'd1) begin n_fail++; $display("FAIL err_consume: got p=%0d cnt=%0d want 254 1", pending, cnt_bin); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (pending !== 8'd0 || cnt_bin !== 8'd0 || err !== 1'b0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got p=%0d cnt=%0d err=%b evt=%b want 0 0 0 0", pending, cnt_bin, err, evt_valid); end
    n_cmp++; if (dut.state !== ST_INIT) begin n_fail++; $display("FAIL async_reset_state: got %0d want %0d", dut.state, ST_INIT); end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (pending !== 8'd0 || cnt_bin !== 8'd1 || dut.state !== ST_TRACK) begin n_fail++; $display("FAIL rerun_init: got p=%0d cnt=%0d st=%0d want 0 1 %0d", pending, cnt_bin, dut.state, ST_TRACK); end
  endtask

  initial begin
    rst_n   = 1'b0;
    gray_in = '0;
    consume = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_latency();
    test_wrap();
    test_jump();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_cnt_receiver.md
GRAY_CNT_RECEIVER -- requirements
Module: gray_cnt_receiver

Interface
REQ-001 SHALL have parameter W (default `INWD): width of the count.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port gray_in, input, W bits: gray-coded count from a remote enable-counter, asynchronous to clk.
REQ-005 SHALL have port consume, input, 1 bit: downstream retires one pending event this cycle.
REQ-006 SHALL have port clr_err, input, 1 bit: clears err and leaves ERR state.
REQ-007 SHALL have port cnt_bin, output, W bits: decoded binary count, registered.
REQ-008 SHALL have port pending, output, W bits: received increments not yet consumed.
REQ-009 SHALL have port evt_valid, output, 1 bit: pending != 0.
REQ-010 SHALL have port err, output, 1 bit: sticky protocol/overflow error.

Function
REQ-011 SHALL pass gray_in through a two-flop synchronizer (sync1, sync2) before any use.
REQ-012 SHALL decode sync2 to binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
REQ-013 SHALL register the decoded value as cnt_bin each cycle; prev holds the last accepted value.
REQ-014 SHALL compute delta = cnt_bin_decoded - prev, modulo 2^W.
REQ-015 SHALL use FSM states INIT, TRACK, ERR.
REQ-016 INIT: SHALL wait 2 cycles for the synchronizer fill, then load prev from the decoded value without counting, then go to TRACK.
REQ-017 TRACK, delta==0: SHALL leave prev and pending unchanged.
REQ-018 TRACK, delta==1: SHALL set prev to the decoded value and increment pending by 1.
REQ-019 TRACK, delta>1: SHALL set err=1, set prev to the decoded value, leave pending unchanged, and go to ERR.
REQ-020 ERR: SHALL keep prev following the decoded value with no counting; clr_err SHALL clear err and go to TRACK.
REQ-021 Wrap: decoded 2^W-1 -> 0 SHALL be treated as delta 1 (valid).
REQ-022 consume with pending==0 SHALL be ignored.
REQ-023 Simultaneous increment and consume SHALL leave pending unchanged.
REQ-024 An increment with pending==2^W-1 SHALL saturate pending, set err=1, and go to ERR.
REQ-025 consume SHALL remain honoured in ERR state.
REQ-026 Latency: a gray_in change before clk edge N SHALL be reflected in pending and cnt_bin after edge N+3.
REQ-027 evt_valid SHALL be combinational from registered pending.

Reset
REQ-028 rst_n low SHALL asynchronously clear sync1, sync2, prev, cnt_bin, pending, err and the fill counter to 0, and set the state to INIT.
REQ-029 Reset asserted mid-operation SHALL discard all pending events; after release the block SHALL re-enter INIT and not count the current remote value.

Structure
REQ-030 W default, the FSM state enum and the sync depth (2) SHALL live in shared package fc_cnt_pkg, with width taken from `INWD in DEF.sv.
REQ-031 The gray-to-binary decode SHALL be a separate combinational sub-module gray2bin (parameter W).
REQ-032 Implementation SHALL use one always_ff per register group and one always_comb for next-state.

Verification (W=8)
REQ-033 Reset release with gray_in=gray(5) held: INIT -> TRACK, cnt_bin=5, pending=0, err=0.
REQ-034 Remote counter steps 5->6->7, one step per 4 cycles, no consume: pending=2, each update 3 edges after the change, evt_valid=1.
REQ-035 gray_in steps 255->0 (gray 0x80 -> 0x00): pending +1, err=0.
REQ-036 gray_in jumps gray(10) -> gray(14): err=1, state ERR, pending unchanged; later steps not counted; clr_err -> TRACK, counting resumes.
REQ-037 Increment and consume in the same cycle with pending=3: pending stays 3; consume at pending=0: stays 0.
REQ-038 pending=255 plus one increment: pending=255, err=1; rst_n pulse mid-stream: all outputs 0, state INIT.
